ov7670_config_sequencer: RTL and testbench
==========================================

# ov7670_config_sequencer

Sequences the camera's SCCB register configuration by walking a register/value table and feeding one entry at a time to the `i2c_sender` write engine through its `send`/`taken` handshake. Handles in-table delay markers and an end marker, and raises `config_finished` once the table is exhausted. Sits between the configuration ROM and `i2c_sender` in the camera front end. A `resend` pulse replays the whole table.

## Interface
- `DEVICE_ID`, 8'h42: SCCB write address driven on `id`.
- `ADDR_W`, 8: ROM address width; the table holds at most 2^ADDR_W entries.
- `DELAY_CYCLES`, 250000: wait length for a delay marker (10 ms at 25 MHz).
- `DELAY_W`, 18: delay counter width; must satisfy DELAY_CYCLES < 2^DELAY_W.
- `clk` in 1: single clock for the block.
- `rst_n` in 1: asynchronous, active-low reset.
- `resend` in 1: single-cycle pulse; restarts the table from address 0.
- `rom_addr` out ADDR_W: registered table address.
- `rom_data` in 16: table entry, valid one cycle after `rom_addr` changes. Bits [15:8] are the register and bits [7:0] are the value.
- `send` out 1: request to `i2c_sender`.
- `taken` in 1: one-cycle acknowledge from `i2c_sender`.
- `id` out 8: constant DEVICE_ID.
- `register` out 8: register address for the current write.
- `value` out 8: data byte for the current write.
- `config_finished` out 1: high while in DONE.

## Operation
- States are FETCH, DECODE, SEND, DELAY and DONE. The block enters FETCH on reset release, so the table runs automatically.
- FETCH: `rom_addr` is stable for one cycle. Next state is DECODE.
- DECODE: `rom_data` is sampled.
  - 16'hFFFF (end marker): go to DONE.
  - 16'hFFF0 (delay marker): load the counter with DELAY_CYCLES-1 and go to DELAY.
  - Any other value: latch `register` and `value`, set `send`=1, and go to SEND.
- SEND: `send`, `register` and `value` are held constant until `taken`=1. On that cycle, clear `send`, increment `rom_addr`, and go to FETCH. There is no timeout; the block waits indefinitely.
- DELAY: the counter decrements every cycle. On the cycle the counter reads 0, increment `rom_addr` and go to FETCH. Total dwell in DELAY is exactly DELAY_CYCLES cycles.
- Table end without a marker: when the entry at address 2^ADDR_W-1 completes (taken or delay expiry), go to DONE. `rom_addr` stays at 2^ADDR_W-1 and does not wrap.
- DONE: `config_finished`=1 and `send`=0. The block stays here until `resend`.
- `resend` handling:
  - In FETCH, DECODE, DELAY or DONE: the next state is FETCH, `rom_addr` becomes 0, `config_finished` is cleared, and any delay is abandoned.
  - In SEND: the pulse is latched as pending. It takes effect on the `taken` cycle, which goes to FETCH with `rom_addr` 0 instead of the increment.
  - `send` is never withdrawn before `taken`.
- `resend` coinciding with the DECODE end marker: the restart wins.
- `resend` coinciding with delay expiry: the restart wins.
- `rom_data` is ignored outside DECODE.

## Timing
- Reset values:
  - `rom_addr`=0, `send`=0, `register`=0, `value`=0, `config_finished`=0.
  - `id`=DEVICE_ID.
  - Pending-resend flag 0, delay counter 0, state FETCH.
- Reset assertion mid-transaction: all outputs return to their reset values immediately (asynchronous). `i2c_sender` completes any transaction it has already accepted.
- Startup: reset deasserts before edge 0. The block is in FETCH at edge 0 and DECODE at edge 1. `send`=1 is visible after edge 1, i.e. during cycle 2.
- After `taken` in cycle t:
  - `send`=0 in cycle t+1, with the block in FETCH on the new address.
  - DECODE in cycle t+2.
  - `send`=1 again in cycle t+3 if the new entry is a write.
- Per-entry overhead is 3 cycles plus the sender's wait time.
- Delay marker decoded in cycle t: FETCH of the next entry occurs in cycle t+1+DELAY_CYCLES.
- `config_finished` rises in the cycle after DECODE sees the end marker. It falls in the cycle after `resend` is seen outside SEND.

## Test plan
- Table {1280, 1204, FFFF}, bench acks with `taken` 5 cycles after each `send`: expect exactly two writes with `id`=42, (12,80) then (12,04). `config_finished`=1 three cycles after the second `taken`, and `rom_addr`=2.
- Table {FFF0, 1100, FFFF} with DELAY_CYCLES=16: expect the first `send` rise exactly 16+3 cycles after the delay is decoded, and write (11,00) follows.
- `resend` while `send`=1 and `taken` is withheld for 50 cycles: expect `send` held with unchanged `register`/`value`. On `taken`, `rom_addr` goes to 0, the table replays from the first entry, and no entry is skipped.
- `resend` mid-DELAY and `resend` in DONE: in both cases expect an immediate return to address 0, `config_finished` going 0 the next cycle, and a full replay.
- ADDR_W=2 with four writes and no end marker: expect four writes, then DONE with `rom_addr`=3 and no wrap to 0.
- `rst_n` pulsed low in SEND: expect `send`, `register`, `value` and `config_finished` at 0 asynchronously. The table restarts from 0 on release, with `send` rising during cycle 2.

Source files
------------

// File: rtl/ov7670_config_sequencer.sv
// Walks the camera register table and hands each (register, value) pair to the SCCB write engine.
// Handles delay and end markers in the table; a resend pulse replays the table from address 0.
module ov7670_config_sequencer #(
  parameter logic [7:0] DEVICE_ID    = 8'h42,
  parameter int         ADDR_W       = 8,
  parameter int         DELAY_CYCLES = 250000,
  parameter int         DELAY_W      = 18
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              resend,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [15:0]       rom_data,
  output logic              send,
  input  logic              taken,
  output logic [7:0]        id,
  output logic [7:0]        register,
  output logic [7:0]        value,
  output logic              config_finished
);

  typedef enum logic [2:0] {FETCH, DECODE, SEND, DELAY, DONE} state_t;

  localparam logic [15:0]        END_MARK   = 16'hFFFF;
  localparam logic [15:0]        DELAY_MARK = 16'hFFF0;
  localparam logic [DELAY_W-1:0] DELAY_LOAD = DELAY_W'(DELAY_CYCLES - 1);

  state_t             state, state_nxt;
  logic [ADDR_W-1:0]  addr_nxt;
  logic               send_nxt;
  logic [7:0]         reg_nxt, val_nxt;
  logic               fin_nxt;
  logic               pend, pend_nxt;
  logic [DELAY_W-1:0] cnt, cnt_nxt;
  logic               last_entry;

  assign id         = DEVICE_ID;
  assign last_entry = &rom_addr;

  always_comb begin
    state_nxt = state;
    addr_nxt  = rom_addr;
    send_nxt  = send;
    reg_nxt   = register;
    val_nxt   = value;
    fin_nxt   = config_finished;
    pend_nxt  = pend;
    cnt_nxt   = cnt;

    case (state)
      FETCH: state_nxt = DECODE;
      DECODE: begin
        if (rom_data == END_MARK) begin
          state_nxt = DONE;
          fin_nxt   = 1'b1;
        end else if (rom_data == DELAY_MARK) begin
          state_nxt = DELAY;
          cnt_nxt   = DELAY_LOAD;
        end else begin
          state_nxt = SEND;
          reg_nxt   = rom_data[15:8];
          val_nxt   = rom_data[7:0];
          send_nxt  = 1'b1;
        end
      end
      SEND: begin
        // A resend here must not yank send; it is honoured once the sender takes the word.
        pend_nxt = pend | resend;
        if (taken) begin
          send_nxt = 1'b0;
          pend_nxt = 1'b0;
          if (pend || resend) begin
            state_nxt = FETCH;
            addr_nxt  = '0;
          end else if (last_entry) begin
            state_nxt = DONE;
            fin_nxt   = 1'b1;
          end else begin
            state_nxt = FETCH;
            addr_nxt  = rom_addr + ADDR_W'(1);
          end
        end
      end
      DELAY: begin
        if (cnt == '0) begin
          if (last_entry) begin
            state_nxt = DONE;
            fin_nxt   = 1'b1;
          end else begin
            state_nxt = FETCH;
            addr_nxt  = rom_addr + ADDR_W'(1);
          end
        end else begin
          cnt_nxt = cnt - DELAY_W'(1);
        end
      end
      DONE: state_nxt = DONE;
      default: state_nxt = FETCH;
    endcase

    // Outside SEND a restart overrides whatever the state decided this cycle.
    if (resend && state != SEND) begin
      state_nxt = FETCH;
      addr_nxt  = '0;
      fin_nxt   = 1'b0;
      cnt_nxt   = '0;
      send_nxt  = 1'b0;
      reg_nxt   = register;
      val_nxt   = value;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= FETCH;
      rom_addr        <= '0;
      send            <= 1'b0;
      register        <= 8'h00;
      value           <= 8'h00;
      config_finished <= 1'b0;
      pend            <= 1'b0;
      cnt             <= '0;
    end else begin
      state           <= state_nxt;
      rom_addr        <= addr_nxt;
      send            <= send_nxt;
      register        <= reg_nxt;
      value           <= val_nxt;
      config_finished <= fin_nxt;
      pend            <= pend_nxt;
      cnt             <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_ov7670_config_sequencer.sv
// Bench for ov7670_config_sequencer: table-driven scenarios on a 4-entry ROM plus
// hand-written resend/reset corner cases. Indices k count negedges after reset release.
module tb_ov7670_config_sequencer;
  localparam int ADDR_W = 2;
  localparam int DC     = 16;
  localparam int DW     = 5;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              resend = 1'b0;
  logic              taken = 1'b0;
  logic [ADDR_W-1:0] rom_addr;
  logic [15:0]       rom_data;
  logic              send;
  logic [7:0]        id;
  logic [7:0]        register;
  logic [7:0]        value;
  logic              config_finished;

  ov7670_config_sequencer #(
    .DEVICE_ID(8'h42), .ADDR_W(ADDR_W), .DELAY_CYCLES(DC), .DELAY_W(DW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .resend(resend), .rom_addr(rom_addr),
    .rom_data(rom_data), .send(send), .taken(taken), .id(id),
    .register(register), .value(value), .config_finished(config_finished)
  );

  always #5 clk = ~clk;

  logic [15:0] rom [4];
  always @(posedge clk) rom_data <= rom[rom_addr];

  typedef struct {
    logic [3:0][15:0] tbl;
    int               nw;
    logic [3:0][15:0] wr;
    int               addr;
    int               first;
    int               done_k;
  } vec_t;

  vec_t vecs [5];

  int checks = 0;
  int errors = 0;
  int nw, first_send, done_idx, fin_addr;
  logic [7:0] wr_reg [8];
  logic [7:0] wr_val [8];
  logic [7:0] wr_id  [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic load(input int i);
    for (int j = 0; j < 4; j++) rom[j] = vecs[i].tbl[j];
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    taken  = 1'b0;
    resend = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic pulse_resend();
    resend = 1'b1;
    @(negedge clk);
    resend = 1'b0;
  endtask

  // Acks each write with taken in the fifth cycle send is seen; stops at config_finished.
  task automatic collect(input int budget);
    int wait_cnt;
    nw = 0; first_send = -1; done_idx = -1; wait_cnt = 0; taken = 1'b0;
    for (int w = 0; w < 8; w++) begin
      wr_reg[w] = 8'h00; wr_val[w] = 8'h00; wr_id[w] = 8'h00;
    end
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (taken) begin
        taken    = 1'b0;
        wait_cnt = 0;
      end else if (send) begin
        if (first_send < 0) first_send = k;
        wait_cnt++;
        if (wait_cnt == 5) begin
          if (nw < 8) begin
            wr_reg[nw] = register; wr_val[nw] = value; wr_id[nw] = id;
          end
          nw++;
          taken = 1'b1;
        end
      end
      if (config_finished) begin
        done_idx = k;
        break;
      end
    end
    taken    = 1'b0;
    fin_addr = int'(rom_addr);
  endtask

  task automatic verify(input string tag, input int i);
    chk($sformatf("%s_nwrites", tag), nw, vecs[i].nw);
    for (int w = 0; w < vecs[i].nw; w++) begin
      chk($sformatf("%s_w%0d_regval", tag, w), {16'h0, wr_reg[w], wr_val[w]}, {16'h0, vecs[i].wr[w]});
      chk($sformatf("%s_w%0d_id", tag, w), wr_id[w], 32'h42);
    end
    chk($sformatf("%s_addr", tag), fin_addr, vecs[i].addr);
    chk($sformatf("%s_first_send", tag), first_send, vecs[i].first);
    chk($sformatf("%s_done_k", tag), done_idx, vecs[i].done_k);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    logic       found, stable;
    logic [7:0] hold_reg, hold_val;

    vecs[0].tbl = {16'h0000, 16'hFFFF, 16'h1204, 16'h1280};
    vecs[0].wr  = {16'h0000, 16'h0000, 16'h1204, 16'h1280};
    vecs[0].nw = 2; vecs[0].addr = 2; vecs[0].first = 1;  vecs[0].done_k = 15;
    vecs[1].tbl = {16'h0000, 16'hFFFF, 16'h1100, 16'hFFF0};
    vecs[1].wr  = {16'h0000, 16'h0000, 16'h0000, 16'h1100};
    vecs[1].nw = 1; vecs[1].addr = 2; vecs[1].first = 19; vecs[1].done_k = 26;
    vecs[2].tbl = {16'h4004, 16'h3003, 16'h2002, 16'h1001};
    vecs[2].wr  = {16'h4004, 16'h3003, 16'h2002, 16'h1001};
    vecs[2].nw = 4; vecs[2].addr = 3; vecs[2].first = 1;  vecs[2].done_k = 27;
    vecs[3].tbl = {16'hFFF0, 16'h5555, 16'hFFF0, 16'hFFF0};
    vecs[3].wr  = {16'h0000, 16'h0000, 16'h0000, 16'h5555};
    vecs[3].nw = 1; vecs[3].addr = 3; vecs[3].first = 37; vecs[3].done_k = 60;
    vecs[4].tbl = {16'h0000, 16'h0000, 16'h0000, 16'hFFFF};
    vecs[4].wr  = {16'h0000, 16'h0000, 16'h0000, 16'h0000};
    vecs[4].nw = 0; vecs[4].addr = 0; vecs[4].first = -1; vecs[4].done_k = 1;

    load(0);
    repeat (2) @(negedge clk);
    chk("rst_addr", rom_addr, 0);
    chk("rst_send", send, 0);
    chk("rst_register", register, 0);
    chk("rst_value", value, 0);
    chk("rst_finished", config_finished, 0);
    chk("rst_id", id, 32'h42);

    for (int i = 0; i < 5; i++) begin
      load(i);
      do_reset();
      collect(120);
      verify($sformatf("vec%0d", i), i);
    end

    // resend while a write is outstanding and taken is withheld
    load(0);
    do_reset();
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      @(negedge clk);
      if (send) found = 1'b1;
    end
    chk("hold_send_seen", found, 1);
    hold_reg = register;
    hold_val = value;
    chk("hold_first_regval", {hold_reg, hold_val}, 32'h1280);
    pulse_resend();
    stable = 1'b1;
    repeat (50) begin
      @(negedge clk);
      if (!send || register != hold_reg || value != hold_val) stable = 1'b0;
    end
    chk("hold_stable", stable, 1);
    taken = 1'b1;
    @(negedge clk);
    taken = 1'b0;
    chk("hold_taken_addr", rom_addr, 0);
    chk("hold_taken_send", send, 0);
    collect(120);
    verify("hold_replay", 0);

    // resend in the middle of a delay
    load(1);
    do_reset();
    repeat (6) @(negedge clk);
    pulse_resend();
    chk("middelay_addr", rom_addr, 0);
    collect(120);
    verify("middelay_replay", 1);

    // resend on the exact cycle the delay expires
    load(1);
    do_reset();
    repeat (17) @(negedge clk);
    pulse_resend();
    chk("expiry_addr", rom_addr, 0);
    collect(120);
    verify("expiry_replay", 1);

    // resend in DONE
    load(0);
    do_reset();
    collect(120);
    chk("done_finished", config_finished, 1);
    pulse_resend();
    chk("done_resend_finished", config_finished, 0);
    chk("done_resend_addr", rom_addr, 0);
    collect(120);
    verify("done_replay", 0);

    // resend coinciding with the end marker in DECODE
    load(4);
    do_reset();
    @(negedge clk);
    pulse_resend();
    chk("endmark_resend_finished", config_finished, 0);
    chk("endmark_resend_addr", rom_addr, 0);
    collect(120);
    verify("endmark_replay", 4);

    // asynchronous reset while a write is pending
    load(0);
    do_reset();
    repeat (3) @(negedge clk);
    chk("arst_pre_send", send, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_send", send, 0);
    chk("arst_register", register, 0);
    chk("arst_value", value, 0);
    chk("arst_finished", config_finished, 0);
    chk("arst_addr", rom_addr, 0);
    @(negedge clk);
    rst_n = 1'b1;
    collect(120);
    verify("arst_replay", 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
